// File: rtl/ccff_bitstream_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : ccff_bitstream_loader_if
// Purpose   : Programming-side bundle for the ccff chain loader: load request,
//             bitstream word handshake, serial chain drive and status.
// Modports  : master - programming controller (drives start/word_*)
//             slave  - ccff_bitstream_loader (drives ready, chain and status)
// Options   : CCFF_LOADER_PARITY_EN adds word_parity (even parity of word_in)
// Revision  : 1.0 - initial release
// ============================================================================
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
);
    logic              start;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
`ifdef CCFF_LOADER_PARITY_EN
    logic              word_parity;
`endif
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              busy;
    logic              done;
    logic              err;

`ifdef CCFF_LOADER_PARITY_EN
    modport master (
        output start, word_in, word_valid, word_parity,
        input  word_ready, ccff_head, ccff_shift_en, busy, done, err
    );
    modport slave (
        input  start, word_in, word_valid, word_parity,
        output word_ready, ccff_head, ccff_shift_en, busy, done, err
    );
`else
    modport master (
        output start, word_in, word_valid,
        input  word_ready, ccff_head, ccff_shift_en, busy, done, err
    );
    modport slave (
        input  start, word_in, word_valid,
        output word_ready, ccff_head, ccff_shift_en, busy, done, err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_bitstream_loader
// Purpose  : Fills one configuration flip-flop chain. Accepts bitstream words
//            on a valid/ready handshake, serialises them MSB first onto
//            ccff_head with a qualifying ccff_shift_en, stops after exactly
//            CHAIN_LEN bits (partial last word truncated) and flags done.
// Ports    : prog_clk - programming clock, rising edge
//            pReset   - asynchronous active-high reset
//            bus      - ccff_bitstream_loader_if.slave:
//                       start, word_in, word_valid, word_ready, [word_parity],
//                       ccff_head, ccff_shift_en, busy, done, err
// Options  : CCFF_LOADER_PARITY_EN - check even parity of {word_in,
//            word_parity} on accept; a mismatch aborts into ERR. Without it
//            err is tied low and no ERR state exists.
// Params   : WORD_W (word width), CHAIN_LEN (1..65535 chain stages),
//            CNT_W (bit counter width, 2**CNT_W > CHAIN_LEN)
// Revision : 1.0 - initial release
// ============================================================================
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  wire logic              prog_clk,
    input  wire logic              pReset,
    ccff_bitstream_loader_if.slave bus
);

    localparam int                  c_WCNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]    c_BCNT_LAST = CNT_W'(CHAIN_LEN - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
`ifdef CCFF_LOADER_PARITY_EN
    localparam logic [2:0] c_ERR   = 3'd4;
`endif

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [WORD_W-1:0]   r_sr;
    logic [CNT_W-1:0]    r_bcnt;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_head;
    logic                r_shift_en;

    logic w_ready;
    logic w_busy;
    logic w_done;
    logic w_err;
    logic w_accept;
    logic w_parity_ok;
    logic w_word_end;
    logic w_chain_end;
    logic w_start_load;

    assign w_accept    = bus.word_valid & w_ready;
    // Both counters describe the bit currently on ccff_head.
    assign w_word_end  = (r_wcnt == c_WCNT_LAST);
    assign w_chain_end = (r_bcnt == c_BCNT_LAST);
    // start only matters from a resting state; LOAD/SHIFT ignore it.
    assign w_start_load = bus.start & (r_state != c_LOAD) & (r_state != c_SHIFT);

`ifdef CCFF_LOADER_PARITY_EN
    assign w_parity_ok = ~^{bus.word_in, bus.word_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_next_state = c_LOAD;
            c_LOAD: begin
                if (w_accept) begin
`ifdef CCFF_LOADER_PARITY_EN
                    w_next_state = w_parity_ok ? c_SHIFT : c_ERR;
`else
                    w_next_state = c_SHIFT;
`endif
                end
            end
            c_SHIFT: begin
                // Chain end wins over word end: a truncated last word stops
                // here and never returns to LOAD.
                if (w_chain_end) begin
                    w_next_state = c_DONE;
                end else if (w_word_end) begin
                    w_next_state = c_LOAD;
                end
            end
            c_DONE:  if (bus.start) w_next_state = c_LOAD;
`ifdef CCFF_LOADER_PARITY_EN
            c_ERR:   if (bus.start) w_next_state = c_LOAD;
`endif
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            c_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            c_SHIFT: w_busy = 1'b1;
            c_DONE:  w_done = 1'b1;
`ifdef CCFF_LOADER_PARITY_EN
            c_ERR:   w_err  = 1'b1;
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift datapath and counters. r_head/r_shift_en are high exactly for
    // the cycles spent in SHIFT. The word MSB goes straight to r_head on
    // accept, so r_sr always holds the bits still waiting behind it.
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_sr       <= '0;
            r_bcnt     <= '0;
            r_wcnt     <= '0;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_bcnt <= '0;
                r_wcnt <= '0;
            end
            if (w_accept && w_parity_ok) begin
                r_sr       <= bus.word_in << 1;
                r_head     <= bus.word_in[WORD_W-1];
                r_shift_en <= 1'b1;
                r_wcnt     <= '0;
            end else if (r_state == c_SHIFT) begin
                r_bcnt <= r_bcnt + CNT_W'(1);
                r_wcnt <= r_wcnt + c_WCNT_W'(1);
                if (w_word_end || w_chain_end) begin
                    r_head     <= 1'b0;
                    r_shift_en <= 1'b0;
                end else begin
                    r_head <= r_sr[WORD_W-1];
                    r_sr   <= r_sr << 1;
                end
            end
        end
    end

    assign bus.word_ready    = w_ready;
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;
    assign bus.err           = w_err;
    assign bus.ccff_head     = r_head;
    assign bus.ccff_shift_en = r_shift_en;

endmodule
`default_nettype wire
